// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage owning the PC and the IF/ID register, with stall, flush and redirect
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_DEPTH = 128,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic        addr_err,
   output logic [31:0] fetch_count
);
   localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);
   logic        in_range;
   logic [31:0] word;
   logic [31:0] pc_next;
   assign imem_addr = {2'b00, pc[31:2]};
   // out-of-range fetches read as NOP instead of whatever the memory returns
   always_comb begin
      in_range = imem_addr < DEPTH;
      word     = in_range ? imem_data : NOP_WORD;
      pc_next  = pc + 32'd4;
   end
   // redirect beats stall; a stall freezes everything; flush only swaps the load for a bubble
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         ifid_instr  <= NOP_WORD;
         ifid_pc     <= '0;
         ifid_pc4    <= '0;
         ifid_valid  <= 1'b0;
         addr_err    <= 1'b0;
         fetch_count <= '0;
      end else if (redirect) begin
         pc         <= {redirect_pc[31:2], 2'b00};
         ifid_instr <= NOP_WORD;
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         pc <= pc_next;
         if (flush) begin
            ifid_instr <= NOP_WORD;
            ifid_valid <= 1'b0;
         end else begin
            ifid_instr  <= word;
            ifid_pc     <= pc;
            ifid_pc4    <= pc_next;
            ifid_valid  <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            if (!in_range) addr_err <= 1'b1;
         end
      end
   end
endmodule
